// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 8-bit binary to 3-digit packed BCD converter,
// one double-dabble step per clock, valid/ready handshakes on both sides.
module bin_to_bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] bcd_out
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] scr_q, scr_d, bcd_q, bcd_d, adj;
   // Digits >= 5 are pre-corrected so the following shift carries into the next decade.
   assign adj[3:0]  = scr_q[3:0]  >= 4'd5 ? scr_q[3:0]  + 4'd3 : scr_q[3:0];
   assign adj[7:4]  = scr_q[7:4]  >= 4'd5 ? scr_q[7:4]  + 4'd3 : scr_q[7:4];
   assign adj[11:8] = scr_q[11:8] >= 4'd5 ? scr_q[11:8] + 4'd3 : scr_q[11:8];
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign bcd_out   = bcd_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            bin_d   = in_data;
            scr_d   = 12'h000;
            cnt_d   = 3'd0;
            state_d = SHIFT;
         end
         SHIFT: begin
            {scr_d, bin_d} = {adj[10:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               bcd_d   = {adj[10:0], bin_q[7]};
               state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         bin_q   <= 8'h00;
         scr_q   <= 12'h000;
         bcd_q   <= 12'h000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         bcd_q   <= bcd_d;
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vector table plus handshake, reset-abort and full-sweep sequences.
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, out_valid;
   logic [11:0] bcd_out;
   int total = 0, bad = 0, cyc = 0;
   typedef struct {logic [7:0] din; logic [11:0] exp; int hold;} vec_t;
   vec_t vecs[8];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   bin_to_bcd_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   // Starts at a falling edge with the block idle, ends at a falling edge back in IDLE.
   task automatic convert(input logic [7:0] din, input logic [11:0] exp, input int hold);
      int k;
      chk("idle_ready", in_ready, 1);
      in_data = din;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_data = ~din;
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("latency", k, 8);
      chk("result", bcd_out, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", bcd_out, exp);
         chk("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("xfer_valid", out_valid, 0);
      chk("xfer_ready", in_ready, 1);
      chk("xfer_keep", bcd_out, exp);
   endtask
   initial begin
      int k, seen, acc, prev;
      logic [11:0] e;
      vecs[0] = '{8'd0,   12'h000, 0};
      vecs[1] = '{8'd255, 12'h255, 0};
      vecs[2] = '{8'd99,  12'h099, 0};
      vecs[3] = '{8'd100, 12'h100, 0};
      vecs[4] = '{8'd9,   12'h009, 0};
      vecs[5] = '{8'd137, 12'h137, 5};
      vecs[6] = '{8'd10,  12'h010, 1};
      vecs[7] = '{8'd59,  12'h059, 0};
      #3;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_bcd", bcd_out, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) convert(vecs[i].din, vecs[i].exp, vecs[i].hold);
      // Input changes every cycle while busy; only the accepted value converts.
      in_data = 8'd77;
      in_valid = 1'b1;
      @(negedge clk);
      k = 0;
      while (!out_valid && k < 20) begin
         chk("busy_ready", in_ready, 0);
         in_data = 8'($urandom);
         @(negedge clk);
         k++;
      end
      chk("busy_latency", k, 8);
      chk("busy_result", bcd_out, 12'h077);
      repeat (2) begin
         in_data = 8'($urandom);
         @(negedge clk);
         chk("done_ready", in_ready, 0);
         chk("done_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("busy_xfer_ready", in_ready, 1);
      chk("busy_xfer_keep", bcd_out, 12'h077);
      // Asynchronous reset in the middle of a conversion.
      in_data = 8'd200;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", in_ready, 1);
      chk("abort_valid", out_valid, 0);
      chk("abort_bcd", bcd_out, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", seen, 0);
      chk("abort_bcd_after", bcd_out, 12'h000);
      convert(8'd42, 12'h042, 0);
      // Back-to-back sweep of every input value.
      in_data = 8'd0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      prev = 0;
      for (int v = 0; v < 256; v++) begin
         k = 0;
         while (!in_ready && k < 30) begin
            @(negedge clk);
            k++;
         end
         in_data = 8'(v);
         acc = cyc;
         @(negedge clk);
         if (v > 0) chk("sweep_spacing", acc - prev, 10);
         prev = acc;
         k = 0;
         while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
         end
         e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         chk("sweep_valid", out_valid, 1);
         chk("sweep_result", bcd_out, e);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
